// File: rtl/cmp_lookup_issuer_pkg.sv
// Shared definitions for the 7-way parallel compare interface.
// Used by the lookup issuer and by the comparator on the other side.
package cmp_lookup_issuer_pkg;

   localparam int unsigned DATA_NUM      = 7;
   localparam int unsigned DATA_WIDTH    = 42;
   localparam int unsigned IDX_WIDTH     = 3;
   // Width of the hit index returned by the comparator
   localparam int unsigned CMP_IDX_WIDTH = IDX_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   // Round-robin successor of an entry slot, wrapping after the last lane
   function automatic logic [IDX_WIDTH-1:0] next_ptr(input logic [IDX_WIDTH-1:0] p);
      return (p == IDX_WIDTH'(DATA_NUM - 1)) ? '0 : p + IDX_WIDTH'(1);
   endfunction

endpackage

// File: rtl/cmp_entry_table.sv
// Key table for the lookup issuer: 7 entry registers, round-robin insert
// pointer and a saturating valid count.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   ins_i        write ins_key_i into slot wr_ptr_o and advance
//   ins_key_i    key to insert
//   flush_i      invalidate the table (count and pointer to 0, data kept)
//   entry_o      all entry registers
//   cnt_o        number of valid entries (0..7)
//   wr_ptr_o     next insert slot
module cmp_entry_table
   import cmp_lookup_issuer_pkg::*;
(
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 ins_i,
   input  logic [DATA_WIDTH-1:0]                ins_key_i,
   input  logic                                 flush_i,
   output logic [DATA_NUM-1:0][DATA_WIDTH-1:0]  entry_o,
   output logic [IDX_WIDTH-1:0]                 cnt_o,
   output logic [IDX_WIDTH-1:0]                 wr_ptr_o
);

   logic [DATA_NUM-1:0][DATA_WIDTH-1:0] entry_q;
   logic [IDX_WIDTH-1:0]                cnt_q;
   logic [IDX_WIDTH-1:0]                wr_ptr_q;

   // Entry data is never cleared by flush; the count masks stale entries
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         entry_q  <= '0;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
      end else begin
         for (int unsigned i = 0; i < DATA_NUM; i++) begin
            if (ins_i && (wr_ptr_q == IDX_WIDTH'(i))) begin
               entry_q[i] <= ins_key_i;
            end
         end
         if (flush_i) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
         end else if (ins_i) begin
            wr_ptr_q <= next_ptr(wr_ptr_q);
            if (cnt_q != IDX_WIDTH'(DATA_NUM)) begin
               cnt_q <= cnt_q + IDX_WIDTH'(1);
            end
         end
      end
   end

   assign entry_o  = entry_q;
   assign cnt_o    = cnt_q;
   assign wr_ptr_o = wr_ptr_q;

endmodule

// File: rtl/cmp_lookup_issuer.sv
// Initiator side of the 7-way parallel compare interface. Accepts lookup
// requests, presents table + key to the comparator, inserts on a miss and
// returns hit/miss/index to the requester.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req_val/req_ready/req_key   lookup request handshake
//   flush                       invalidate the whole table
//   d_val, d0..d6, ref_d,
//   d_val_cnt                   compare request to the comparator
//   res_val/res_hit/res_idx     compare result from the comparator
//   rsp_val/rsp_ready/rsp_hit/
//   rsp_idx/rsp_ins             lookup response handshake
module cmp_lookup_issuer
   import cmp_lookup_issuer_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_val,
   output logic                     req_ready,
   input  logic [DATA_WIDTH-1:0]    req_key,
   input  logic                     flush,
   output logic                     d_val,
   output logic [DATA_WIDTH-1:0]    d0,
   output logic [DATA_WIDTH-1:0]    d1,
   output logic [DATA_WIDTH-1:0]    d2,
   output logic [DATA_WIDTH-1:0]    d3,
   output logic [DATA_WIDTH-1:0]    d4,
   output logic [DATA_WIDTH-1:0]    d5,
   output logic [DATA_WIDTH-1:0]    d6,
   output logic [DATA_WIDTH-1:0]    ref_d,
   output logic [IDX_WIDTH-1:0]     d_val_cnt,
   input  logic                     res_val,
   input  logic                     res_hit,
   input  logic [CMP_IDX_WIDTH-1:0] res_idx,
   output logic                     rsp_val,
   input  logic                     rsp_ready,
   output logic                     rsp_hit,
   output logic [IDX_WIDTH-1:0]     rsp_idx,
   output logic                     rsp_ins
);

   state_e                              state_q;
   logic                                req_ready_q;
   logic                                d_val_q;
   logic [DATA_WIDTH-1:0]               ref_d_q;
   logic                                rsp_val_q;
   logic                                rsp_hit_q;
   logic [IDX_WIDTH-1:0]                rsp_idx_q;
   logic                                rsp_ins_q;
   logic                                flush_pend_q;

   logic [DATA_NUM-1:0][DATA_WIDTH-1:0] entry;
   logic [IDX_WIDTH-1:0]                cnt;
   logic [IDX_WIDTH-1:0]                wr_ptr;
   logic                                hit_c;
   logic                                ins_c;
   logic                                tbl_flush_c;

   // A hit on an index outside the valid range is a stale entry: treat as miss
   assign hit_c = res_hit && (IDX_WIDTH'(res_idx) < cnt);
   assign ins_c = (state_q == ST_WAIT) && res_val && !hit_c;

   // Table may only change in IDLE/RESP (flush) and WAIT (insert), so the
   // contents seen by the comparator during ISSUE are always stable
   assign tbl_flush_c = ((state_q == ST_IDLE) && flush) ||
                        ((state_q == ST_RESP) && (flush || flush_pend_q));

   cmp_entry_table u_table (
      .clk       (clk),
      .rst_n     (rst_n),
      .ins_i     (ins_c),
      .ins_key_i (ref_d_q),
      .flush_i   (tbl_flush_c),
      .entry_o   (entry),
      .cnt_o     (cnt),
      .wr_ptr_o  (wr_ptr)
   );

   // Lookup FSM with registered handshake and compare outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         req_ready_q  <= 1'b0;
         d_val_q      <= 1'b0;
         ref_d_q      <= '0;
         rsp_val_q    <= 1'b0;
         rsp_hit_q    <= 1'b0;
         rsp_idx_q    <= '0;
         rsp_ins_q    <= 1'b0;
         flush_pend_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_val && req_ready_q) begin
                  ref_d_q     <= req_key;
                  d_val_q     <= 1'b1;
                  req_ready_q <= 1'b0;
                  state_q     <= ST_ISSUE;
               end else begin
                  req_ready_q <= 1'b1;
               end
            end
            ST_ISSUE: begin
               d_val_q <= 1'b0;
               if (flush) flush_pend_q <= 1'b1;
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (flush) flush_pend_q <= 1'b1;
               if (res_val) begin
                  rsp_val_q <= 1'b1;
                  rsp_hit_q <= hit_c;
                  rsp_idx_q <= hit_c ? IDX_WIDTH'(res_idx) : wr_ptr;
                  rsp_ins_q <= !hit_c;
                  state_q   <= ST_RESP;
               end
            end
            ST_RESP: begin
               // Pending flush is consumed by tbl_flush_c in this state
               flush_pend_q <= 1'b0;
               if (rsp_ready) begin
                  rsp_val_q   <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready = req_ready_q;
   assign d_val     = d_val_q;
   assign ref_d     = ref_d_q;
   assign d_val_cnt = cnt;
   assign rsp_val   = rsp_val_q;
   assign rsp_hit   = rsp_hit_q;
   assign rsp_idx   = rsp_idx_q;
   assign rsp_ins   = rsp_ins_q;
   assign d0 = entry[0];
   assign d1 = entry[1];
   assign d2 = entry[2];
   assign d3 = entry[3];
   assign d4 = entry[4];
   assign d5 = entry[5];
   assign d6 = entry[6];

endmodule

// File: tb/tb_cmp_lookup_issuer.sv
// Directed bench for cmp_lookup_issuer; the bench plays both the requester
// and the comparator.
module tb_cmp_lookup_issuer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_val;
   logic        req_ready;
   logic [41:0] req_key;
   logic        flush;
   logic        d_val;
   logic [41:0] d0, d1, d2, d3, d4, d5, d6;
   logic [41:0] ref_d;
   logic [2:0]  d_val_cnt;
   logic        res_val;
   logic        res_hit;
   logic [2:0]  res_idx;
   logic        rsp_val;
   logic        rsp_ready;
   logic        rsp_hit;
   logic [2:0]  rsp_idx;
   logic        rsp_ins;

   int total = 0;
   int bad   = 0;

   // Values captured by the protocol helpers
   logic        c_dval1, c_dval2, c_rspval, c_hit, c_ins;
   logic [2:0]  c_cnt_issue, c_idx;

   cmp_lookup_issuer dut (
      .clk(clk), .rst_n(rst_n), .req_val(req_val), .req_ready(req_ready),
      .req_key(req_key), .flush(flush), .d_val(d_val),
      .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6),
      .ref_d(ref_d), .d_val_cnt(d_val_cnt), .res_val(res_val),
      .res_hit(res_hit), .res_idx(res_idx), .rsp_val(rsp_val),
      .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_idx(rsp_idx),
      .rsp_ins(rsp_ins)
   );

   always #5 clk = ~clk;

   task automatic apply_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Handshake a request (optionally with flush) and step into WAIT
   task automatic start_lookup(input logic [41:0] key, input logic with_flush);
      int n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (!req_ready) begin
         bad++;
         $display("FAIL req_ready_timeout got=%0b exp=1", req_ready);
      end
      req_val = 1'b1;
      req_key = key;
      flush   = with_flush;
      @(negedge clk);
      req_val = 1'b0;
      flush   = 1'b0;
      c_dval1     = d_val;
      c_cnt_issue = d_val_cnt;
      @(negedge clk);
      c_dval2 = d_val;
   endtask

   // Comparator answers for one cycle; capture the response that follows
   task automatic give_result(input logic h, input logic [2:0] ix);
      res_val = 1'b1;
      res_hit = h;
      res_idx = ix;
      @(negedge clk);
      res_val  = 1'b0;
      res_hit  = 1'b0;
      res_idx  = '0;
      c_rspval = rsp_val;
      c_hit    = rsp_hit;
      c_idx    = rsp_idx;
      c_ins    = rsp_ins;
   endtask

   task automatic accept_rsp();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic lookup(input logic [41:0] key, input logic h, input logic [2:0] ix);
      start_lookup(key, 1'b0);
      give_result(h, ix);
      accept_rsp();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%0b exp=0", req_ready); end
      total++; if (d_val !== 1'b0) begin bad++; $display("FAIL rst_d_val got=%0b exp=0", d_val); end
      total++; if (rsp_val !== 1'b0) begin bad++; $display("FAIL rst_rsp_val got=%0b exp=0", rsp_val); end
      total++; if (ref_d !== 42'h0) begin bad++; $display("FAIL rst_ref_d got=%0h exp=0", ref_d); end
      total++; if (d_val_cnt !== 3'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", d_val_cnt); end
      total++; if ({rsp_hit, rsp_ins, rsp_idx} !== 5'd0) begin bad++; $display("FAIL rst_rsp_fields got=%0h exp=0", {rsp_hit, rsp_ins, rsp_idx}); end
      total++; if (d0 !== 42'h0 || d6 !== 42'h0) begin bad++; $display("FAIL rst_entries got=%0h/%0h exp=0/0", d0, d6); end
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_idle_ready got=%0b exp=1", req_ready); end
   endtask

   task automatic test_single_miss();
      start_lookup(42'h123, 1'b0);
      total++; if (c_dval1 !== 1'b1) begin bad++; $display("FAIL t1_dval_issue got=%0b exp=1", c_dval1); end
      total++; if (c_dval2 !== 1'b0) begin bad++; $display("FAIL t1_dval_once got=%0b exp=0", c_dval2); end
      total++; if (c_cnt_issue !== 3'd0) begin bad++; $display("FAIL t1_cnt_issue got=%0d exp=0", c_cnt_issue); end
      total++; if (ref_d !== 42'h123) begin bad++; $display("FAIL t1_ref_d got=%0h exp=123", ref_d); end
      give_result(1'b0, 3'd0);
      total++; if (c_rspval !== 1'b1) begin bad++; $display("FAIL t1_rsp_val got=%0b exp=1", c_rspval); end
      total++; if ({c_hit, c_ins, c_idx} !== {1'b0, 1'b1, 3'd0}) begin bad++; $display("FAIL t1_rsp got hit=%0b ins=%0b idx=%0d exp hit=0 ins=1 idx=0", c_hit, c_ins, c_idx); end
      accept_rsp();
      total++; if (d0 !== 42'h123) begin bad++; $display("FAIL t1_d0 got=%0h exp=123", d0); end
      total++; if (d_val_cnt !== 3'd1) begin bad++; $display("FAIL t1_cnt got=%0d exp=1", d_val_cnt); end
   endtask

   task automatic test_hit();
      apply_reset();
      lookup(42'h10, 1'b0, 3'd0);
      lookup(42'h11, 1'b0, 3'd0);
      lookup(42'h12, 1'b0, 3'd0);
      start_lookup(42'h11, 1'b0);
      total++; if (c_cnt_issue !== 3'd3) begin bad++; $display("FAIL t2_cnt_issue got=%0d exp=3", c_cnt_issue); end
      give_result(1'b1, 3'd1);
      total++; if ({c_hit, c_ins, c_idx} !== {1'b1, 1'b0, 3'd1}) begin bad++; $display("FAIL t2_hit got hit=%0b ins=%0b idx=%0d exp hit=1 ins=0 idx=1", c_hit, c_ins, c_idx); end
      accept_rsp();
      total++; if (d_val_cnt !== 3'd3) begin bad++; $display("FAIL t2_cnt got=%0d exp=3", d_val_cnt); end
      // Hit index beyond the valid count is a miss and inserts at slot 3
      lookup(42'h13, 1'b1, 3'd5);
      total++; if ({c_hit, c_ins, c_idx} !== {1'b0, 1'b1, 3'd3}) begin bad++; $display("FAIL t2_stale_idx got hit=%0b ins=%0b idx=%0d exp hit=0 ins=1 idx=3", c_hit, c_ins, c_idx); end
      total++; if (d_val_cnt !== 3'd4 || d3 !== 42'h13) begin bad++; $display("FAIL t2_stale_ins got cnt=%0d d3=%0h exp cnt=4 d3=13", d_val_cnt, d3); end
   endtask

   task automatic test_wrap();
      apply_reset();
      for (int i = 0; i < 7; i++) begin
         lookup(42'hA0 + 42'(i), 1'b0, 3'd0);
         total++; if (c_idx !== 3'(i)) begin bad++; $display("FAIL t3_fill_idx got=%0d exp=%0d", c_idx, i); end
      end
      total++; if (d_val_cnt !== 3'd7) begin bad++; $display("FAIL t3_full_cnt got=%0d exp=7", d_val_cnt); end
      lookup(42'hA7, 1'b0, 3'd0);
      total++; if ({c_ins, c_idx} !== {1'b1, 3'd0}) begin bad++; $display("FAIL t3_wrap got ins=%0b idx=%0d exp ins=1 idx=0", c_ins, c_idx); end
      total++; if (d0 !== 42'hA7 || d1 !== 42'hA1) begin bad++; $display("FAIL t3_wrap_data got d0=%0h d1=%0h exp d0=a7 d1=a1", d0, d1); end
      total++; if (d_val_cnt !== 3'd7) begin bad++; $display("FAIL t3_sat_cnt got=%0d exp=7", d_val_cnt); end
      lookup(42'hA8, 1'b0, 3'd0);
      total++; if (c_idx !== 3'd1 || d1 !== 42'hA8) begin bad++; $display("FAIL t3_next got idx=%0d d1=%0h exp idx=1 d1=a8", c_idx, d1); end
   endtask

   task automatic test_rsp_stall();
      // Table is full with wr_ptr=2 after the wrap test
      start_lookup(42'h55, 1'b0);
      give_result(1'b0, 3'd0);
      for (int i = 0; i < 5; i++) begin
         total++;
         if (rsp_val !== 1'b1 || rsp_hit !== 1'b0 || rsp_ins !== 1'b1 || rsp_idx !== 3'd2 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL t4_hold cyc=%0d got val=%0b hit=%0b ins=%0b idx=%0d rdy=%0b exp val=1 hit=0 ins=1 idx=2 rdy=0",
                     i, rsp_val, rsp_hit, rsp_ins, rsp_idx, req_ready);
         end
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      total++; if (rsp_val !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL t4_release got val=%0b rdy=%0b exp val=0 rdy=1", rsp_val, req_ready); end
   endtask

   task automatic test_flush();
      apply_reset();
      lookup(42'h20, 1'b0, 3'd0);
      lookup(42'h21, 1'b0, 3'd0);
      start_lookup(42'h77, 1'b0);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      give_result(1'b0, 3'd0);
      total++; if ({c_rspval, c_ins, c_idx} !== {1'b1, 1'b1, 3'd2}) begin bad++; $display("FAIL t5_inflight got val=%0b ins=%0b idx=%0d exp val=1 ins=1 idx=2", c_rspval, c_ins, c_idx); end
      accept_rsp();
      total++; if (d_val_cnt !== 3'd0) begin bad++; $display("FAIL t5_flushed_cnt got=%0d exp=0", d_val_cnt); end
      // Comparator still matches stale data in lane 2; count masks it
      start_lookup(42'h77, 1'b0);
      total++; if (c_cnt_issue !== 3'd0) begin bad++; $display("FAIL t5_cnt_issue got=%0d exp=0", c_cnt_issue); end
      give_result(1'b1, 3'd2);
      accept_rsp();
      total++; if ({c_hit, c_ins, c_idx} !== {1'b0, 1'b1, 3'd0}) begin bad++; $display("FAIL t5_relookup got hit=%0b ins=%0b idx=%0d exp hit=0 ins=1 idx=0", c_hit, c_ins, c_idx); end
      // Flush together with a request handshake: lookup sees an empty table
      start_lookup(42'h88, 1'b1);
      total++; if (c_cnt_issue !== 3'd0) begin bad++; $display("FAIL t5_flush_req_cnt got=%0d exp=0", c_cnt_issue); end
      give_result(1'b1, 3'd0);
      accept_rsp();
      total++; if ({c_hit, c_ins, c_idx} !== {1'b0, 1'b1, 3'd0}) begin bad++; $display("FAIL t5_flush_req got hit=%0b ins=%0b idx=%0d exp hit=0 ins=1 idx=0", c_hit, c_ins, c_idx); end
      total++; if (d_val_cnt !== 3'd1 || d0 !== 42'h88) begin bad++; $display("FAIL t5_flush_req_tbl got cnt=%0d d0=%0h exp cnt=1 d0=88", d_val_cnt, d0); end
   endtask

   task automatic test_reset_in_wait();
      start_lookup(42'h31, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      res_val = 1'b1;
      res_hit = 1'b0;
      @(negedge clk);
      res_val = 1'b0;
      @(negedge clk);
      total++; if (rsp_val !== 1'b0) begin bad++; $display("FAIL t6_rsp_val got=%0b exp=0", rsp_val); end
      total++; if (d_val_cnt !== 3'd0 || d0 !== 42'h0) begin bad++; $display("FAIL t6_table got cnt=%0d d0=%0h exp cnt=0 d0=0", d_val_cnt, d0); end
      total++; if (req_ready !== 1'b1 || d_val !== 1'b0) begin bad++; $display("FAIL t6_idle got rdy=%0b dval=%0b exp rdy=1 dval=0", req_ready, d_val); end
      // Issuer is usable again after the abandoned lookup
      lookup(42'h32, 1'b0, 3'd0);
      total++; if ({c_ins, c_idx} !== {1'b1, 3'd0} || d0 !== 42'h32) begin bad++; $display("FAIL t6_after got ins=%0b idx=%0d d0=%0h exp ins=1 idx=0 d0=32", c_ins, c_idx, d0); end
   endtask

   initial begin
      rst_n     = 1'b0;
      req_val   = 1'b0;
      req_key   = '0;
      flush     = 1'b0;
      res_val   = 1'b0;
      res_hit   = 1'b0;
      res_idx   = '0;
      rsp_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_single_miss();
      test_hit();
      test_wrap();
      test_rsp_stall();
      test_flush();
      test_reset_in_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cmp_lookup_issuer.md
Name: cmp_lookup_issuer

Overview:
Initiator side of the 7-way parallel compare interface. It owns a 7-entry key table and accepts lookup requests over a valid/ready handshake. For each request it drives the table contents, the request key and the valid-entry count to the parallel comparator, waits for the compare result, and inserts the key on a miss using round-robin replacement. It then returns hit/miss/index to the requester over a second valid/ready handshake.

Parameters:
DATA_NUM, 7, number of table entries / comparator lanes; fixed at 7 to match the comparator.
DATA_WIDTH, 42, key width in bits.
IDX_WIDTH, 3, width of entry index and valid count; must hold the value DATA_NUM.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, synchronous, active-low.
req_val  in  1  lookup request valid.
req_ready  out  1  issuer can accept a request.
req_key  in  DATA_WIDTH  key to look up.
flush  in  1  one-cycle pulse that invalidates the whole table.
d_val  out  1  one-cycle compare strobe to the comparator.
d0..d6  out  DATA_WIDTH each  table entries 0..6, driven directly from entry registers.
ref_d  out  DATA_WIDTH  registered key under compare.
d_val_cnt  out  IDX_WIDTH  number of valid entries; entries 0..cnt-1 are valid.
res_val  in  1  compare result valid.
res_hit  in  1  compare hit.
res_idx  in  IDX_WIDTH  index of the hit entry.
rsp_val  out  1  response valid.
rsp_ready  in  1  requester accepts the response.
rsp_hit  out  1  key was already present.
rsp_idx  out  IDX_WIDTH  hit index, or the slot the key was inserted into on a miss.
rsp_ins  out  1  key was inserted on this lookup; asserted only on a miss.

Behaviour:
- Reset (rst_n=0 sampled at a clk edge):
  - State returns to IDLE.
  - Outputs cleared: req_ready=0 during reset, d_val=0, ref_d=0, rsp_val=0, rsp_hit=0, rsp_idx=0, rsp_ins=0.
  - Table state cleared: cnt=0, wr_ptr=0, all entries=0.
  - Reset mid-lookup abandons the lookup; a late res_val is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: req_ready=1. A handshake (req_val & req_ready) latches req_key into ref_d, then go to ISSUE.
  - ISSUE: d_val=1 for exactly one cycle; d0..d6 and d_val_cnt are stable this cycle. Go to WAIT.
  - WAIT: hold until res_val=1; only res_val sampled in WAIT is honoured. The comparator latency is one cycle, but any latency of 1 or more must work.
    - Hit (res_hit=1): rsp_hit=1, rsp_idx=res_idx, rsp_ins=0. res_idx >= cnt is treated as a miss.
    - Miss: entry[wr_ptr]<=ref_d, rsp_hit=0, rsp_idx=wr_ptr, rsp_ins=1. Then wr_ptr<=wr_ptr+1, wrapping 6->0. cnt<=cnt+1, saturating at 7.
    - Either way, rsp_val<=1 and go to RESP.
  - RESP: hold rsp_* stable until rsp_ready=1. On that edge rsp_val<=0 and go to IDLE.
- Throughput: one lookup per 4 cycles minimum. req_ready=0 in every state except IDLE.
- Replacement when full: round-robin. The 8th distinct key overwrites entry 0, the 9th overwrites entry 1, and so on. Once full, cnt stays 7.
- flush:
  - Honoured in IDLE and RESP: cnt<=0, wr_ptr<=0. Entry data is left as-is; it is masked by d_val_cnt.
  - In ISSUE/WAIT, flush is registered as pending and applied when the FSM reaches RESP. The in-flight lookup's insert still happens, then is discarded by the flush.
  - Simultaneous flush and request handshake in IDLE: the flush applies first, so the lookup sees cnt=0 and always misses.
- Duplicate protection: a miss never creates a duplicate key because the table only changes in WAIT.

Decomposition:
- Shared package: DATA_NUM, DATA_WIDTH and IDX_WIDTH defaults; FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3); a compare-interface constant for the hit-index width. The package is shared with the comparator.
- One natural sub-module, cmp_entry_table. It holds the 7 entry registers, wr_ptr and cnt, and takes insert and flush controls. It exposes d0..d6, d_val_cnt and the next insert slot.
- The FSM and both handshakes stay in the top level.

Test Plan:
1. Reset, then a single lookup of key 0x123 on an empty table -> d_val pulses once with d_val_cnt=0. Response is rsp_hit=0, rsp_ins=1, rsp_idx=0. After it, d0=0x123 and d_val_cnt=1.
2. Insert keys 0x10, 0x11, 0x12, then look up 0x11 -> rsp_hit=1, rsp_idx=1, rsp_ins=0; cnt stays 3.
3. Insert 7 distinct keys 0xA0..0xA6, then 0xA7 -> 0xA7 gets rsp_idx=0, rsp_ins=1, d0=0xA7, d_val_cnt=7. The next new key goes to idx 1.
4. Hold rsp_ready=0 for 5 cycles -> rsp_val and rsp_* stay stable and req_ready=0. After rsp_ready=1, rsp_val drops and req_ready=1 the next cycle.
5. Flush asserted during WAIT of a miss -> the response still reports rsp_ins=1 with its idx. Afterwards d_val_cnt=0, and looking up the same key misses at idx 0.
6. rst_n=0 for one cycle while in WAIT, then a delayed res_val=1 -> the late result is ignored, rsp_val stays 0 and d_val_cnt=0.
